// File: rtl/sign_mag_to_bcd.sv
// sign_mag_to_bcd: sequential double-dabble converter from N-bit sign-magnitude
// to a sign flag plus packed BCD digits for the seven-segment display path.
// One conversion is accepted per start while idle. It runs for N cycles and
// finishes with a one-cycle done pulse.
// Optional feature: define SMBCD_BLANK_EN to generate the leading-zero blank
// mask. Without it, blank_o is tied to zero.
module sign_mag_to_bcd #(
    parameter int unsigned N      = 8,
    parameter int unsigned DIGITS = 3
) (
    input  logic                  clk,
    input  logic                  rst_n,
    input  logic                  start_i,
    input  logic [N-1:0]          sm_in_i,
    output logic                  busy_o,
    output logic                  done_o,
    output logic                  neg_o,
    output logic [4*DIGITS-1:0]   bcd_o,
    output logic [DIGITS-1:0]     blank_o
);

    localparam int unsigned BCD_W = 4 * DIGITS;
    localparam int unsigned CNT_W = (N > 1) ? $clog2(N) : 1;

    typedef enum logic {
        IDLE = 1'b0,
        CONV = 1'b1
    } state_t;

    state_t             state_q, state_d;
    logic [CNT_W-1:0]   cnt_q, cnt_d;
    logic [N-1:0]       mag_q, mag_d;
    logic               sign_q, sign_d;
    logic [BCD_W-1:0]   scratch_q, scratch_d;
    logic [BCD_W-1:0]   bcd_q, bcd_d;
    logic               neg_q, neg_d;
    logic               done_q, done_d;
    logic               busy_q, busy_d;

    logic [BCD_W-1:0]   scratch_adj;
    logic [BCD_W-1:0]   scratch_sh;
    logic [N-1:0]       mag_sh;
    logic               neg_zero;

    // Double-dabble correction: a digit of 5 or more gets +3 before the shift.
    function automatic logic [3:0] dd_adjust(input logic [3:0] d);
        return (d >= 4'd5) ? 4'(d + 4'd3) : d;
    endfunction

    // Correct and shift the scratch digits and the magnitude for one iteration.
    always_comb begin
        scratch_adj = '0;
        for (int i = 0; i < int'(DIGITS); i++) begin
            scratch_adj[4*i +: 4] = dd_adjust(scratch_q[4*i +: 4]);
        end
        scratch_sh = {scratch_adj[BCD_W-2:0], mag_q[N-1]};
        mag_sh     = {mag_q[N-2:0], 1'b0};
    end

    // Sign bit set with a zero magnitude means the most negative value, -2^(N-1).
    assign neg_zero = sm_in_i[N-1] && (sm_in_i[N-2:0] == '0);

    // Next-state logic: capture the operand on start, iterate, publish the result on the last pass.
    always_comb begin
        state_d   = state_q;
        cnt_d     = cnt_q;
        mag_d     = mag_q;
        sign_d    = sign_q;
        scratch_d = scratch_q;
        bcd_d     = bcd_q;
        neg_d     = neg_q;
        done_d    = 1'b0;
        busy_d    = busy_q;

        case (state_q)
            IDLE: begin
                if (start_i) begin
                    sign_d    = sm_in_i[N-1];
                    mag_d     = neg_zero ? {1'b1, {(N-1){1'b0}}}
                                         : {1'b0, sm_in_i[N-2:0]};
                    scratch_d = '0;
                    cnt_d     = '0;
                    state_d   = CONV;
                    busy_d    = 1'b1;
                end
            end
            CONV: begin
                scratch_d = scratch_sh;
                mag_d     = mag_sh;
                cnt_d     = cnt_q + CNT_W'(1);
                if (cnt_q == CNT_W'(N - 1)) begin
                    bcd_d   = scratch_sh;
                    neg_d   = sign_q;
                    done_d  = 1'b1;
                    busy_d  = 1'b0;
                    cnt_d   = '0;
                    state_d = IDLE;
                end
            end
            default: begin
                state_d = IDLE;
                busy_d  = 1'b0;
            end
        endcase
    end

    // State and datapath registers with synchronous active-low reset.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state_q   <= IDLE;
            cnt_q     <= '0;
            mag_q     <= '0;
            sign_q    <= 1'b0;
            scratch_q <= '0;
            bcd_q     <= '0;
            neg_q     <= 1'b0;
            done_q    <= 1'b0;
            busy_q    <= 1'b0;
        end else begin
            state_q   <= state_d;
            cnt_q     <= cnt_d;
            mag_q     <= mag_d;
            sign_q    <= sign_d;
            scratch_q <= scratch_d;
            bcd_q     <= bcd_d;
            neg_q     <= neg_d;
            done_q    <= done_d;
            busy_q    <= busy_d;
        end
    end

    assign busy_o = busy_q;
    assign done_o = done_q;
    assign neg_o  = neg_q;
    assign bcd_o  = bcd_q;

`ifdef SMBCD_BLANK_EN
    logic [DIGITS-1:0] blank_q, blank_d;
    logic              hi_zero;

    // Blank a digit when it and every higher digit of the next bcd value are zero. Never blank the ones digit.
    always_comb begin
        blank_d = '0;
        hi_zero = 1'b1;
        for (int i = int'(DIGITS) - 1; i >= 0; i--) begin
            hi_zero    = hi_zero && (bcd_d[4*i +: 4] == 4'd0);
            blank_d[i] = (i != 0) && hi_zero;
        end
    end

    // Blank mask register. It follows bcd, so it changes on the same edge.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            blank_q <= {{(DIGITS-1){1'b1}}, 1'b0};
        end else begin
            blank_q <= blank_d;
        end
    end

    assign blank_o = blank_q;
`else
    assign blank_o = '0;
`endif

endmodule

// File: tb/tb_sign_mag_to_bcd.sv
// Scoreboard bench for sign_mag_to_bcd (N=8, DIGITS=3). Each accepted start
// pushes the expected result and done cycle. A monitor pops and compares the
// queue entry on every done pulse.
module tb_sign_mag_to_bcd;

    localparam int unsigned N      = 8;
    localparam int unsigned DIGITS = 3;
    localparam int unsigned BW     = 4 * DIGITS;

`ifdef SMBCD_BLANK_EN
    localparam logic [DIGITS-1:0] RST_BLANK = 3'b110;
`else
    localparam logic [DIGITS-1:0] RST_BLANK = 3'b000;
`endif

    typedef struct {
        logic              neg;
        logic [BW-1:0]     bcd;
        logic [DIGITS-1:0] blank;
        int unsigned       due;
    } exp_t;

    logic              clk = 1'b0;
    logic              rst_n = 1'b0;
    logic              start = 1'b0;
    logic [N-1:0]      sm = '0;
    logic              busy, done, neg;
    logic [BW-1:0]     bcd;
    logic [DIGITS-1:0] blank;

    int unsigned cyc = 0;
    int unsigned n_checks = 0;
    int unsigned n_pass = 0;
    exp_t        sb[$];

    sign_mag_to_bcd #(.N(N), .DIGITS(DIGITS)) dut (
        .clk     (clk),
        .rst_n   (rst_n),
        .start_i (start),
        .sm_in_i (sm),
        .busy_o  (busy),
        .done_o  (done),
        .neg_o   (neg),
        .bcd_o   (bcd),
        .blank_o (blank)
    );

    always #5 clk = ~clk;
    always @(posedge clk) cyc <= cyc + 1;

    task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got === exp) n_pass++;
        else $display("FAIL %s: got %0h expected %0h (cycle %0d)", tag, got, exp, cyc);
    endtask

    // Reference result built with decimal division, independent of double-dabble.
    function automatic exp_t model(input logic [N-1:0] v, input int unsigned due);
        exp_t e;
        int   mag;
        logic hz;
        if (v == 8'h80) begin
            e.neg = 1'b1;
            mag   = 128;
        end else begin
            e.neg = v[7];
            mag   = int'(v[6:0]);
        end
        e.bcd = '0;
        for (int d = 0; d < int'(DIGITS); d++) begin
            e.bcd[4*d +: 4] = 4'(mag % 10);
            mag = mag / 10;
        end
        e.blank = '0;
`ifdef SMBCD_BLANK_EN
        hz = 1'b1;
        for (int i = int'(DIGITS) - 1; i >= 0; i--) begin
            hz = hz && (e.bcd[4*i +: 4] == 4'd0);
            e.blank[i] = (i > 0) && hz;
        end
`else
        hz = 1'b0;
        e.blank = {DIGITS{hz}};
`endif
        e.due = due;
        return e;
    endfunction

    // Monitor: every done pulse must match the oldest outstanding expectation.
    always @(negedge clk) begin
        if (done) begin
            if (sb.size() == 0) begin
                check_eq("spurious_done", 32'(done), 32'(0));
            end else begin
                exp_t e;
                e = sb.pop_front();
                check_eq("latency", 32'(cyc), 32'(e.due));
                check_eq("neg", 32'(neg), 32'(e.neg));
                check_eq("bcd", 32'(bcd), 32'(e.bcd));
                check_eq("blank", 32'(blank), 32'(e.blank));
                check_eq("busy_with_done", 32'(busy), 32'(0));
            end
        end
    end

    task automatic check_reset_state();
        check_eq("rst_busy", 32'(busy), 32'(0));
        check_eq("rst_done", 32'(done), 32'(0));
        check_eq("rst_neg", 32'(neg), 32'(0));
        check_eq("rst_bcd", 32'(bcd), 32'(0));
        check_eq("rst_blank", 32'(blank), 32'(RST_BLANK));
    endtask

    // Pulse start for one cycle while idle and record the expected result.
    task automatic start_conv(input logic [N-1:0] v);
        @(negedge clk);
        sm    = v;
        start = 1'b1;
        sb.push_back(model(v, cyc + 1 + N));
        @(negedge clk);
        start = 1'b0;
        check_eq("busy_after_start", 32'(busy), 32'(1));
    endtask

    task automatic wait_drain();
        for (int i = 0; i < int'(N) + 4 && sb.size() != 0; i++) begin
            @(negedge clk);
            #1;
        end
        if (sb.size() != 0) begin
            check_eq("drain_timeout", 32'(sb.size()), 32'(0));
            sb.delete();
        end
    endtask

    task automatic do_conv(input logic [N-1:0] v);
        start_conv(v);
        wait_drain();
    endtask

    initial begin
        logic [N-1:0] vals[3];
        logic         seen;

        // Reset held for two edges.
        rst_n = 1'b0;
        repeat (2) @(negedge clk);
        check_reset_state();
        rst_n = 1'b1;

        // Directed values: positive, negative, positive max, zero, negative zero.
        do_conv(8'b0010_1101);
        do_conv(8'b1110_0100);
        do_conv(8'b0111_1111);
        do_conv(8'h00);
        do_conv(8'b1000_0000);

        // A start and an operand change during busy must be ignored.
        start_conv(8'b0010_1101);
        repeat (2) @(negedge clk);
        sm    = 8'h63;
        start = 1'b1;
        @(negedge clk);
        start = 1'b0;
        sm    = 8'h11;
        seen  = 1'b0;
        for (int i = 0; i < int'(N) + 4 && !seen; i++) begin
            @(negedge clk);
            if (done) begin
                seen  = 1'b1;
                sm    = 8'h63;
                start = 1'b1;
                sb.push_back(model(8'h63, cyc + 1 + N));
            end
        end
        check_eq("done_seen_busy_test", 32'(seen), 32'(1));
        @(negedge clk);
        start = 1'b0;
        wait_drain();

        // Start held high continuously: one conversion every N+1 cycles.
        vals[0] = 8'h05;
        vals[1] = 8'h99;
        vals[2] = 8'hFF;
        for (int k = 0; k < 3; k++) begin
            seen = 1'b0;
            for (int i = 0; i < int'(N) + 4 && !seen; i++) begin
                @(negedge clk);
                if (!busy) seen = 1'b1;
            end
            check_eq("idle_seen_stream", 32'(seen), 32'(1));
            sm    = vals[k];
            start = 1'b1;
            sb.push_back(model(vals[k], cyc + 1 + N));
            @(posedge clk);
        end
        @(negedge clk);
        start = 1'b0;
        wait_drain();

        // Reset in the middle of a conversion aborts it without a done pulse.
        start_conv(8'b0010_1101);
        repeat (3) @(negedge clk);
        rst_n = 1'b0;
        @(negedge clk);
        sb.delete();
        check_reset_state();
        rst_n = 1'b1;
        repeat (N + 2) @(negedge clk);
        check_eq("no_done_after_abort", 32'(done), 32'(0));
        do_conv(8'h63);

        // Random operands.
        repeat (6) do_conv(8'($urandom_range(0, 255)));

        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

    initial begin
        #100000;
        $display("FAIL watchdog: simulation did not finish, got timeout expected finish");
        $fatal(1);
    end

endmodule

// File: doc/sign_mag_to_bcd.md
# sign_mag_to_bcd

Sequential double-dabble converter that takes the N-bit sign-magnitude result produced by the calculator's two's-complement-to-sign-magnitude stage and turns it into a sign flag plus packed BCD digits for the seven-segment display driver. It sits directly downstream of that converter and upstream of the display decoder. One conversion is started per `start` pulse, runs for N cycles, and is reported with a one-cycle `done` pulse.

## Interface
- `N`, 8: width of `sm_in`. Bit N-1 is the sign and bits N-2..0 are the magnitude.
- `DIGITS`, 3: number of BCD digits output. It must satisfy 10^DIGITS > 2^(N-1).
- `clk`  in  1  single clock; all state changes on the rising edge.
- `rst_n`  in  1  reset, synchronous, active-low.
- `start`  in  1  request a conversion; sampled only while `busy`=0.
- `sm_in`  in  N  sign-magnitude operand; captured on the edge that accepts `start`.
- `busy`  out  1  high while a conversion is in progress.
- `done`  out  1  one-cycle pulse on the edge that `bcd`/`neg` update.
- `neg`  out  1  sign of the last completed result.
- `bcd`  out  4*DIGITS  packed BCD, with digit 0 (ones) in bits [3:0]. Held until the next `done`.
- `blank`  out  DIGITS  leading-zero blank mask, one bit per digit. See Configuration.

## Operation
- States:
  - IDLE: `busy`=0.
  - CONV: `busy`=1. An internal counter `cnt` (width clog2(N)) tracks iterations.
- IDLE, `start`=1 at an edge:
  - Capture `neg_r` = `sm_in[N-1]`.
  - Capture `mag_r` (N bits) = {0, `sm_in[N-2:0]`}.
  - Clear the scratch BCD register. Set `cnt`=0. Go to CONV.
- Negative-zero rule: `sm_in` = 1 followed by all zeros is the upstream encoding of -2^(N-1). It is captured as `neg_r`=1 with `mag_r`=2^(N-1). For N=8 this is -128.
- Positive zero (all bits 0) gives `neg_r`=0, `mag_r`=0.
- Each CONV edge, in order:
  1. Every scratch digit ≥5 gets +3.
  2. {scratch, `mag_r`} shifts left by 1.
  3. `cnt` increments.
- When `cnt`=N-1 at a CONV edge:
  - The final iteration's value is written to `bcd`, and `neg`=`neg_r`.
  - `done`=1 for that cycle only. State returns to IDLE.
- `start` while `busy`=1 is ignored, and `sm_in` changes during CONV are ignored.
- `start` high in the cycle where `done`=1 is accepted, because the state is already IDLE.
- `rst_n`=0 at any edge, including mid-CONV:
  - State goes to IDLE. `busy`=0, `done`=0, `neg`=0, `bcd`=0, scratch and counter cleared.
  - `blank` takes its reset value (see Configuration).
  - An aborted conversion never produces `done`.

## Timing
- Latency: `start` is accepted at edge E0; `bcd`/`neg`/`done` update at edge E0+N (8 cycles for N=8).
- `busy` goes high after E0 and low at E0+N. `busy` and `done` are never both 1.
- Throughput: one conversion per N+1 cycles when `start` is held high continuously.
- All outputs are registered; there is no combinational path from inputs to outputs.

## Configuration
- `SMBCD_BLANK_EN` defined:
  - `blank[i]`=1 when digit i and every higher digit of `bcd` are 0, for i ≥ 1. `blank[0]` is always 0.
  - `blank` updates on the same edge as `bcd`.
  - Reset value is all ones except bit 0.
- `SMBCD_BLANK_EN` undefined:
  - `blank` is tied to all zeros, including during reset.
  - No blanking logic is synthesized.

## Test plan
- Reset: hold `rst_n`=0 for 2 cycles. Required: `busy`=0, `done`=0, `neg`=0, `bcd`=12'h000, and `blank`=3'b110 (macro on) or 3'b000 (macro off).
- Positive value: `sm_in`=8'b0010_1101, `start` for 1 cycle. Required: exactly 8 edges later `done`=1 for 1 cycle, `neg`=0, `bcd`=12'h045, `blank`=3'b100 (macro on).
- Negative, positive max and zero:
  - `sm_in`=8'b1110_0100 gives `neg`=1, `bcd`=12'h100.
  - `sm_in`=8'b0111_1111 gives `neg`=0, `bcd`=12'h127.
  - `sm_in`=8'h00 gives `neg`=0, `bcd`=12'h000.
- Negative zero: `sm_in`=8'b1000_0000 gives `neg`=1, `bcd`=12'h128.
- Busy and back-to-back behaviour:
  - Start 45; pulse `start` with 99 at cycle 3 and change `sm_in`. Required: result is still 12'h045 and no second `done`.
  - Then `start` with 99 during the `done` cycle. Required: 12'h099 arrives 8 edges later.
- Reset mid-conversion: assert `rst_n`=0 for 1 cycle at cycle 4 of a conversion. Required: no `done`, outputs at their reset values, and a new conversion afterwards completes normally.
